divisor_sequencial_arb: RTL and testbench

Two-requester arbiter and sequencer for a shared 8-bit unsigned divider in the ULA. It accepts division requests from two requesters and grants them round-robin. Each granted operation runs a restoring division at one quotient bit per clock, then returns Q, R and a divide-by-zero flag with a one-cycle done pulse tagged with the requester id. It replaces one combinational divider per requester with a single multi-cycle unit, which shortens the ULA critical path.

---
 rtl/ula_div_pkg.sv | 16 +
 rtl/divisor_passo.sv | 19 +
 rtl/divisor_sequencial_arb.sv | 140 ++++++++++++++
 tb/tb_divisor_sequencial_arb.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ula_div_pkg.sv
// Shared constants and FSM state type for the ULA sequential divider.
package ula_div_pkg;

    localparam int DIV_W  = 8;
    localparam int ITER_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam logic [DIV_W-1:0] Q_DIV_ZERO = 8'hFF;
    localparam logic [DIV_W-1:0] R_DIV_ZERO = 8'h00;

endpackage

// File: rtl/divisor_passo.sv
// One combinational restoring-division step: shift in a dividend bit, subtract if it fits.
module divisor_passo
    import ula_div_pkg::*;
(
    input  logic [DIV_W:0]   p,
    input  logic             d_bit,
    input  logic [DIV_W-1:0] b,
    output logic [DIV_W:0]   p_next,
    output logic             q_bit
);

    logic [DIV_W:0] t;

    // The partial remainder stays below b, so bit DIV_W of p is always zero here.
    assign t      = {p[DIV_W-1:0], d_bit};
    assign q_bit  = (t >= {1'b0, b});
    assign p_next = q_bit ? (t - {1'b0, b}) : t;

endmodule

// File: rtl/divisor_sequencial_arb.sv
// Round-robin two-requester front end for a one-bit-per-clock restoring divider.
// Define DIV_EARLY_EXIT_EN to finish B==0 and A<B operations straight from capture.
module divisor_sequencial_arb
    import ula_div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [DIV_W-1:0] A0,
    input  logic [DIV_W-1:0] B0,
    input  logic             req1,
    input  logic [DIV_W-1:0] A1,
    input  logic [DIV_W-1:0] B1,
    output logic             ack0,
    output logic             ack1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [DIV_W-1:0] Q,
    output logic [DIV_W-1:0] R,
    output logic             div_zero
);

    div_state_t        state, state_next;
    logic [ITER_W-1:0] iter;
    logic [DIV_W:0]    p;
    logic [DIV_W-1:0]  d;
    logic [DIV_W-1:0]  qs;
    logic [DIV_W-1:0]  b_reg;
    logic              cur_id;
    logic              last_served;

    logic              grant_any;
    logic              grant_id;
    logic [DIV_W-1:0]  a_sel;
    logic [DIV_W-1:0]  b_sel;
    logic              early;
    logic [DIV_W:0]    p_next;
    logic              q_bit;

    divisor_passo u_passo (
        .p      (p),
        .d_bit  (d[DIV_W-1]),
        .b      (b_reg),
        .p_next (p_next),
        .q_bit  (q_bit)
    );

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_any = req0 | req1;
        grant_id  = (req0 & req1) ? ~last_served : req1;
        a_sel     = grant_id ? A1 : A0;
        b_sel     = grant_id ? B1 : B0;
`ifdef DIV_EARLY_EXIT_EN
        early     = (b_sel == '0) || (a_sel < b_sel);
`else
        early     = 1'b0;
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_any) state_next = early ? DONE : CALC;
            CALC: if (iter == '0) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    assign busy = (state == CALC) || (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            iter        <= '0;
            p           <= '0;
            d           <= '0;
            qs          <= '0;
            b_reg       <= '0;
            cur_id      <= 1'b0;
            last_served <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            done        <= 1'b0;
            done_id     <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_zero    <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        cur_id <= grant_id;
                        b_reg  <= b_sel;
                        d      <= a_sel;
                        p      <= '0;
                        qs     <= '0;
                        iter   <= ITER_W'(DIV_W - 1);
                        ack0   <= ~grant_id;
                        ack1   <= grant_id;
                        if (early) begin
                            done        <= 1'b1;
                            done_id     <= grant_id;
                            last_served <= grant_id;
                            div_zero    <= (b_sel == '0);
                            Q           <= (b_sel == '0) ? Q_DIV_ZERO : '0;
                            R           <= (b_sel == '0) ? R_DIV_ZERO : a_sel;
                        end
                    end
                end
                CALC: begin
                    d    <= d << 1;
                    p    <= p_next;
                    qs   <= {qs[DIV_W-2:0], q_bit};
                    iter <= iter - 1'b1;
                    // The last step's bit is folded straight into the result.
                    if (iter == '0) begin
                        done        <= 1'b1;
                        done_id     <= cur_id;
                        last_served <= cur_id;
                        div_zero    <= (b_reg == '0);
                        Q           <= (b_reg == '0) ? Q_DIV_ZERO : {qs[DIV_W-2:0], q_bit};
                        R           <= (b_reg == '0) ? R_DIV_ZERO : p_next[DIV_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divisor_sequencial_arb.sv
// Directed bench for divisor_sequencial_arb with a result scoreboard; honours DIV_EARLY_EXIT_EN.
module tb_divisor_sequencial_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1;
    logic [7:0] A0, B0, A1, B1;
    logic       ack0, ack1, busy, done, done_id, div_zero;
    logic [7:0] Q, R;

    divisor_sequencial_arb dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .A0       (A0),
        .B0       (B0),
        .req1     (req1),
        .A1       (A1),
        .B1       (B1),
        .ack0     (ack0),
        .ack1     (ack1),
        .busy     (busy),
        .done     (done),
        .done_id  (done_id),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int unsigned last_done_cyc = 0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    // Expected record: {id, div_zero, Q, R}
    function automatic logic [17:0] model(input logic id, input logic [7:0] a, input logic [7:0] b);
        if (b == 8'd0) return {id, 1'b1, 8'hFF, 8'h00};
        return {id, 1'b0, 8'(a / b), 8'(a % b)};
    endfunction

    function automatic int unsigned lat(input logic [7:0] a, input logic [7:0] b);
`ifdef DIV_EARLY_EXIT_EN
        if (b == 8'd0 || a < b) return 1;
`endif
        return 9;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            last_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL unexpected_done: observed done=1 expected no pending op");
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_id",  32'(done_id),  32'(mon_e[17]));
                chk("div_zero", 32'(div_zero), 32'(mon_e[16]));
                chk("q",        32'(Q),        32'(mon_e[15:8]));
                chk("r",        32'(R),        32'(mon_e[7:0]));
            end
        end
    end

    task automatic drive(input logic id, input logic [7:0] a, input logic [7:0] b);
        if (id) begin req1 = 1'b1; A1 = a; B1 = b; end
        else    begin req0 = 1'b1; A0 = a; B0 = b; end
    endtask

    task automatic wait_ack(input logic id, output logic got);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id ? ack1 : ack0) begin
                got = 1'b1;
                break;
            end
        end
        if (id) req1 = 1'b0; else req0 = 1'b0;
        chk("ack_seen", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run_op(input logic id, input logic [7:0] a, input logic [7:0] b);
        int unsigned start;
        logic got;
        drive(id, a, b);
        start = cyc;
        exp_q.push_back(model(id, a, b));
        wait_ack(id, got);
        if (got) begin
            @(negedge clk);
            chk("ack_pulse", 32'(id ? ack1 : ack0), 32'd0);
        end
        drain();
        if (got) chk("latency", last_done_cyc - start, lat(a, b));
    endtask

    // Both requesters raise together; returns the id acknowledged first.
    task automatic run_tie(output logic first_id);
        logic s0, s1, any;
        s0 = 1'b0; s1 = 1'b0; any = 1'b0; first_id = 1'b1;
        drive(1'b0, 8'd50, 8'd5);
        drive(1'b1, 8'd9, 8'd4);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (ack0) begin
                if (!any) first_id = 1'b0;
                any = 1'b1; s0 = 1'b1; req0 = 1'b0;
            end
            if (ack1) begin
                if (!any) first_id = 1'b1;
                any = 1'b1; s1 = 1'b1; req1 = 1'b0;
            end
            if (s0 && s1) break;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("tie_both_acked", 32'({s0, s1}), 32'b11);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack0"},     32'(ack0),     32'd0);
        chk({tag, "_ack1"},     32'(ack1),     32'd0);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_done_id"},  32'(done_id),  32'd0);
        chk({tag, "_div_zero"}, 32'(div_zero), 32'd0);
        chk({tag, "_q"},        32'(Q),        32'd0);
        chk({tag, "_r"},        32'(R),        32'd0);
    endtask

    initial begin
        logic       first;
        logic       got;
        logic [7:0] ra, rb;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        reset_dut();
        chk_reset_outputs("reset");

        // Tie after reset: requester 0 first, then 1, then 0 again on the next tie.
        exp_q.push_back(model(1'b0, 8'd50, 8'd5));
        exp_q.push_back(model(1'b1, 8'd9, 8'd4));
        run_tie(first);
        chk("tie_first_grant", 32'(first), 32'd0);
        drain();
        exp_q.push_back(model(1'b0, 8'd50, 8'd5));
        exp_q.push_back(model(1'b1, 8'd9, 8'd4));
        run_tie(first);
        chk("rr_next_grant", 32'(first), 32'd0);
        drain();

        run_op(1'b0, 8'd100, 8'd7);
        run_op(1'b1, 8'd255, 8'd1);
        run_op(1'b1, 8'd0,   8'd9);
        run_op(1'b0, 8'd5,   8'd0);
        run_op(1'b0, 8'd3,   8'd9);
        run_op(1'b0, 8'd9,   8'd3);
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_op(1'($urandom_range(0, 1)), ra, rb);
        end

        // Abort mid-calculation: no done, outputs back to reset values.
        drive(1'b0, 8'd200, 8'd3);
        wait_ack(1'b0, got);
        repeat (3) @(negedge clk);
        chk("busy_in_calc", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("abort");
        repeat (12) @(negedge clk);
        run_op(1'b0, 8'd200, 8'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
